// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the multicycle data-memory
//                responder (FSM state encoding, data/strobe widths, latency
//                limit).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_DATA_WIDTH  = 64;
    localparam int DMEM_STRB_WIDTH  = 8;
    localparam int DMEM_MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Synchronous single-port storage, DEPTH x 64 bits, with a
//                per-byte write enable and a registered read port. Contents
//                are deliberately not reset.
//  Ports       : clk    - clock
//                en     - access enable (one read or write this edge)
//                we     - 1 = write enabled byte lanes, 0 = read
//                addr   - word index
//                wdata  - write data
//                wstrb  - byte-lane enables for writes
//                rdata  - registered read data (updates on reads only)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int IDX_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [IDX_WIDTH-1:0]       addr,
    input  logic [DMEM_DATA_WIDTH-1:0] wdata,
    input  logic [DMEM_STRB_WIDTH-1:0] wstrb,
    output logic [DMEM_DATA_WIDTH-1:0] rdata
);

    logic [DMEM_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DMEM_DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DMEM_STRB_WIDTH; i++) begin
                    if (wstrb[i]) begin
                        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory-side responder for the CPU data port. Accepts one
//                load/store at a time (valid/ready), waits LATENCY cycles,
//                performs the access on the edge entering RESP, and holds the
//                response until the requester takes it.
//  Ports       : clk, reset_b (async, active-low)
//                req_valid/req_ready   - request handshake
//                req_write, req_addr, req_wdata, req_wstrb - request payload
//                resp_valid/resp_ready - response handshake
//                resp_rdata, resp_err  - response payload
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int LATENCY         = 2      // legal range 0..15
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
    input  logic [DMEM_STRB_WIDTH-1:0] req_wstrb,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DMEM_DATA_WIDTH-1:0] resp_rdata,
    output logic                       resp_err
);

    localparam int          c_CNT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0]  c_CNT_LOAD = c_CNT_INIT[3:0];
    localparam bit          c_ZERO_LAT = (LATENCY == 0);
    localparam logic [31:0] c_DEPTH    = 32'(DMEM_DEPTH);
    localparam int          c_IDX_W    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    dmem_state_t r_state;
    dmem_state_t w_next_state;

    logic [3:0]                 r_cnt;
    logic                       r_write;
    logic [DMEM_ADDR_WIDTH-1:0] r_addr;
    logic [DMEM_DATA_WIDTH-1:0] r_wdata;
    logic [DMEM_STRB_WIDTH-1:0] r_wstrb;
    logic                       r_resp_err;
    logic                       r_resp_is_load;

    logic                       w_accept;
    logic                       w_access;
    logic                       w_acc_write;
    logic [DMEM_ADDR_WIDTH-1:0] w_acc_addr;
    logic [DMEM_DATA_WIDTH-1:0] w_acc_wdata;
    logic [DMEM_STRB_WIDTH-1:0] w_acc_wstrb;
    logic                       w_in_range;
    logic [DMEM_DATA_WIDTH-1:0] w_arr_rdata;

    assign w_accept = req_valid && (r_state == IDLE);

    // With zero latency the access happens on the accept edge itself, before
    // the request latch holds anything, so the live request is used then.
    // In every other case the latched copy is used.
    assign w_access = ((r_state == WAIT) && (r_cnt == 4'd0)) ||
                      (c_ZERO_LAT && w_accept);

    assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_acc_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;

    assign w_in_range = (32'(w_acc_addr) < c_DEPTH);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = c_ZERO_LAT ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------- request latch and counter
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_CNT_LOAD;
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------- response qualifiers
    // The array read register only updates on a load, so muxing it with a
    // "this response was a load" flag keeps resp_rdata at 0 for stores and
    // errors and stable for as long as RESP lasts.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_resp_err     <= 1'b0;
            r_resp_is_load <= 1'b0;
        end else if (w_access) begin
            r_resp_err     <= !w_in_range;
            r_resp_is_load <= !w_acc_write && w_in_range;
        end
    end

    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_is_load ? w_arr_rdata : '0;

    // --------------------------------------------------------------- array
    dmem_array #(
        .DEPTH     (DMEM_DEPTH),
        .IDX_WIDTH (c_IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (w_access && w_in_range),
        .we    (w_acc_write),
        .addr  (w_acc_addr[c_IDX_W-1:0]),
        .wdata (w_acc_wdata),
        .wstrb (w_acc_wstrb),
        .rdata (w_arr_rdata)
    );

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Four instances with
//                different LATENCY / DMEM_DEPTH settings; a vector table for
//                basic load/store behaviour plus directed sequences for
//                backpressure, out-of-range and reset-in-flight cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int N = 4;

    // Instance 0: L=2/1024, 1: L=2/512, 2: L=4/1024, 3: L=0/1024
    function automatic int lat_of(input int i);
        case (i)
            2:       return 4;
            3:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int dep_of(input int i);
        return (i == 1) ? 512 : 1024;
    endfunction

    logic        clk = 1'b0;
    logic        reset_b    [N];
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_write  [N];
    logic [9:0]  req_addr   [N];
    logic [63:0] req_wdata  [N];
    logic [7:0]  req_wstrb  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [63:0] resp_rdata [N];
    logic        resp_err   [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DMEM_DEPTH      (dep_of(g)),
            .DMEM_ADDR_WIDTH (10),
            .LATENCY         (lat_of(g))
        ) u_dut (
            .clk        (clk),
            .reset_b    (reset_b[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_wstrb  (req_wstrb[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, wait for the response. cyc = 1 means resp_valid was
    // already high just after the accept edge. If resp_ready is high the
    // handshake edge is consumed before returning.
    task automatic do_req(input int i, input logic w, input logic [9:0] a,
                          input logic [63:0] d, input logic [7:0] s,
                          output logic [63:0] rd, output logic er, output int cyc);
        int guard;
        guard = 0;
        while (!req_ready[i] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_wstrb[i] = s;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        // Garble the payload after accept; the DUT must use its latched copy.
        req_write[i] = ~w;
        req_addr[i]  = a ^ 10'h3;
        req_wdata[i] = ~d;
        req_wstrb[i] = ~s;
        cyc = 1;
        while (!resp_valid[i] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        rd = resp_rdata[i];
        er = resp_err[i];
        if (resp_ready[i]) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        w;
        logic [9:0]  a;
        logic [63:0] d;
        logic [7:0]  s;
        logic [63:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          cyc;

        vecs[0] = '{1'b1, 10'd5,    64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 10'd5,    64'h0,                8'h00, 64'h1122334455667788, 1'b0};
        vecs[2] = '{1'b1, 10'd5,    64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
        vecs[3] = '{1'b0, 10'd5,    64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
        vecs[4] = '{1'b1, 10'd5,    64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0};
        vecs[5] = '{1'b0, 10'd5,    64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
        vecs[6] = '{1'b1, 10'd1023, 64'hCAFEF00DDEADBEEF, 8'hFF, 64'h0, 1'b0};
        vecs[7] = '{1'b0, 10'd1023, 64'h0,                8'h00, 64'hCAFEF00DDEADBEEF, 1'b0};
        vecs[8] = '{1'b1, 10'd5,    64'h5555555555555555, 8'h81, 64'h0, 1'b0};
        vecs[9] = '{1'b0, 10'd5,    64'h0,                8'h00, 64'h55223344AAAAAA55, 1'b0};

        for (int i = 0; i < N; i++) begin
            reset_b[i]    = 1'b0;
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
            req_wstrb[i]  = '0;
            resp_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) reset_b[i] = 1'b1;
        @(posedge clk); #1;

        // Reset state on every instance
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_req_ready[%0d]", i),  64'(req_ready[i]),  64'd1);
            check($sformatf("rst_resp_valid[%0d]", i), 64'(resp_valid[i]), 64'd0);
            check($sformatf("rst_resp_rdata[%0d]", i), resp_rdata[i],      64'd0);
            check($sformatf("rst_resp_err[%0d]", i),   64'(resp_err[i]),   64'd0);
        end

        // Vector table on instance 0 (LATENCY=2)
        for (int v = 0; v < 10; v++) begin
            do_req(0, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].s, rd, er, cyc);
            check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
            check($sformatf("vec%0d_err", v), 64'(er), 64'(vecs[v].exp_er));
            check($sformatf("vec%0d_latency", v), 64'(cyc), 64'd3);
        end

        // Backpressure: load addr 5 with resp_ready low for 10 cycles
        resp_ready[0] = 1'b0;
        do_req(0, 1'b0, 10'd5, 64'h0, 8'h00, rd, er, cyc);
        check("bp_latency", 64'(cyc), 64'd3);
        check("bp_rdata", rd, 64'h55223344AAAAAA55);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_valid_c%0d", k), 64'(resp_valid[0]), 64'd1);
            check($sformatf("bp_stable_c%0d", k), resp_rdata[0], 64'h55223344AAAAAA55);
            check($sformatf("bp_req_ready_c%0d", k), 64'(req_ready[0]), 64'd0);
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(resp_valid[0]), 64'd0);
        check("bp_release_idle", 64'(req_ready[0]), 64'd1);

        // Out of range on instance 1 (DMEM_DEPTH=512)
        do_req(1, 1'b1, 10'd88, 64'h0123456789ABCDEF, 8'hFF, rd, er, cyc);
        check("oor_seed_err", 64'(er), 64'd0);
        do_req(1, 1'b1, 10'd600, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, er, cyc);
        check("oor_store_err", 64'(er), 64'd1);
        check("oor_store_rdata", rd, 64'd0);
        check("oor_store_latency", 64'(cyc), 64'd3);
        do_req(1, 1'b0, 10'd600, 64'h0, 8'h00, rd, er, cyc);
        check("oor_load_err", 64'(er), 64'd1);
        check("oor_load_rdata", rd, 64'd0);
        do_req(1, 1'b0, 10'd88, 64'h0, 8'h00, rd, er, cyc);
        check("oor_alias_rdata", rd, 64'h0123456789ABCDEF);
        check("oor_alias_err", 64'(er), 64'd0);
        do_req(1, 1'b1, 10'd511, 64'h0BADC0DE0BADC0DE, 8'hFF, rd, er, cyc);
        check("edge511_store_err", 64'(er), 64'd0);
        do_req(1, 1'b0, 10'd511, 64'h0, 8'h00, rd, er, cyc);
        check("edge511_load_rdata", rd, 64'h0BADC0DE0BADC0DE);
        do_req(1, 1'b0, 10'd512, 64'h0, 8'h00, rd, er, cyc);
        check("edge512_err", 64'(er), 64'd1);
        check("edge512_rdata", rd, 64'd0);

        // Reset during WAIT on instance 2 (LATENCY=4): store is dropped
        do_req(2, 1'b1, 10'd7, 64'h0F0E0D0C0B0A0908, 8'hFF, rd, er, cyc);
        check("l4_seed_latency", 64'(cyc), 64'd5);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 10'd7;
        req_wdata[2] = 64'h1111111111111111;
        req_wstrb[2] = 8'hFF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        check("l4_in_wait", 64'(req_ready[2]), 64'd0);
        @(posedge clk); #1;
        reset_b[2] = 1'b0;
        #1;
        check("l4_rst_req_ready", 64'(req_ready[2]), 64'd1);
        check("l4_rst_resp_valid", 64'(resp_valid[2]), 64'd0);
        @(posedge clk); #1;
        reset_b[2] = 1'b1;
        @(posedge clk); #1;
        do_req(2, 1'b0, 10'd7, 64'h0, 8'h00, rd, er, cyc);
        check("l4_dropped_store", rd, 64'h0F0E0D0C0B0A0908);

        // Zero latency on instance 3: store commits at accept, survives reset
        do_req(3, 1'b1, 10'd7, 64'h0F0E0D0C0B0A0908, 8'hFF, rd, er, cyc);
        check("l0_seed_latency", 64'(cyc), 64'd1);
        req_valid[3] = 1'b1;
        req_write[3] = 1'b1;
        req_addr[3]  = 10'd7;
        req_wdata[3] = 64'h2222222222222222;
        req_wstrb[3] = 8'hFF;
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        check("l0_resp_next_cycle", 64'(resp_valid[3]), 64'd1);
        check("l0_store_rdata", resp_rdata[3], 64'd0);
        reset_b[3] = 1'b0;
        #1;
        check("l0_rst_resp_valid", 64'(resp_valid[3]), 64'd0);
        check("l0_rst_req_ready", 64'(req_ready[3]), 64'd1);
        @(posedge clk); #1;
        reset_b[3] = 1'b1;
        @(posedge clk); #1;
        do_req(3, 1'b0, 10'd7, 64'h0, 8'h00, rd, er, cyc);
        check("l0_committed_store", rd, 64'h2222222222222222);
        check("l0_load_latency", 64'(cyc), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
